// File: rtl/bit_packer16_if.sv
// Handshake bundle for the serial-to-parallel packer: bit stream in, word stream out.
// Both sides use valid/ready: a transfer happens at a rising edge where valid && ready are both high.
interface bit_packer16_if #(
  parameter int WIDTH = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_valid
  );

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_valid
  );
endinterface

// File: rtl/bit_packer16.sv
// Collects WIDTH accepted serial bits into one word.
// Sustains one bit per cycle with no bubble between consecutive words.
module bit_packer16 #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  bit_packer16_if.slave bus,
  output logic [CW-1:0] bit_count,
  output logic          dbg_state
);
  typedef enum logic {FILL, LAST} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] word_q;
  logic             word_valid_q;
  logic [CW-1:0]    pos;
  logic             at_last;
  logic             slot_free;
  logic             bit_ready;
  logic             accept;

  assign at_last   = (count_q == CW'(WIDTH - 1));
  assign slot_free = !word_valid_q || bus.word_ready;
  // Only the completing bit waits for the output slot; earlier bits keep flowing.
  assign bit_ready = !rst && !clear && !(at_last && !slot_free);
  assign accept    = bus.bit_valid && bit_ready;
  assign pos       = LSB_FIRST ? count_q : (CW'(WIDTH - 1) - count_q);

  always_comb begin
    acc_d      = acc_q;
    acc_d[pos] = bus.bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      count_q      <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      if (word_valid_q && bus.word_ready) begin
        word_valid_q <= 1'b0;
      end
      if (clear) begin
        state_q <= FILL;
        count_q <= '0;
        acc_q   <= '0;
      end else if (accept) begin
        if (at_last) begin
          word_q       <= acc_d;
          word_valid_q <= 1'b1;
          count_q      <= '0;
          acc_q        <= '0;
          state_q      <= FILL;
        end else begin
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          state_q <= (count_q == CW'(WIDTH - 2)) ? LAST : FILL;
        end
      end
    end
  end

  assign bus.bit_ready  = bit_ready;
  assign bus.word_out   = word_q;
  assign bus.word_valid = word_valid_q;
  assign bit_count      = count_q;
  assign dbg_state      = (state_q == LAST);
endmodule

// File: tb/tb_bit_packer16.sv
// Bench for bit_packer16: directed scenarios plus random traffic against a queue-based model.
// Two instances (LSB-first and MSB-first) share the same stimulus.
module tb_bit_packer16;
  logic clk = 1'b0;
  logic rst, clear, bit_in, bit_valid, word_ready;
  logic [3:0] count_a, count_b;
  logic dbg_a, dbg_b;
  logic chk_en = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  bit_packer16_if #(.WIDTH(16)) if_a ();
  bit_packer16_if #(.WIDTH(16)) if_b ();

  assign if_a.bit_in = bit_in;
  assign if_a.bit_valid = bit_valid;
  assign if_a.word_ready = word_ready;
  assign if_b.bit_in = bit_in;
  assign if_b.bit_valid = bit_valid;
  assign if_b.word_ready = word_ready;

  bit_packer16 #(.WIDTH(16), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_a), .bit_count(count_a), .dbg_state(dbg_a)
  );
  bit_packer16 #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_b), .bit_count(count_b), .dbg_state(dbg_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // behavioural model: partial word as a list of accepted bits, one output slot
  bit m_bits[$];
  bit m_valid = 1'b0;
  logic [15:0] m_word_a = '0;
  logic [15:0] m_word_b = '0;
  logic [15:0] exp_q[$];

  function automatic bit model_ready();
    return !rst && !clear && !(m_bits.size() == 15 && m_valid && !word_ready);
  endfunction

  function automatic logic [15:0] pack(input bit lsb);
    logic [15:0] w = '0;
    for (int k = 0; k < 16; k++) begin
      if (lsb) w[k] = m_bits[k];
      else w[15-k] = m_bits[k];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    bit took;
    if (rst) begin
      m_bits.delete();
      m_valid = 1'b0;
      m_word_a = '0;
      m_word_b = '0;
      exp_q.delete();
    end else begin
      took = bit_valid && model_ready();
      if (m_valid && word_ready) m_valid = 1'b0;
      if (clear) m_bits.delete();
      else if (took) begin
        m_bits.push_back(bit_in);
        if (m_bits.size() == 16) begin
          m_word_a = pack(1'b1);
          m_word_b = pack(1'b0);
          m_valid = 1'b1;
          exp_q.push_back(m_word_a);
          m_bits.delete();
        end
      end
    end
  end

  // compare process plus scoreboard of handed-off words
  always @(negedge clk) begin
    logic [15:0] e;
    if (chk_en) begin
      check("bit_ready_a", if_a.bit_ready, model_ready());
      check("bit_ready_b", if_b.bit_ready, model_ready());
      check("word_valid_a", if_a.word_valid, m_valid);
      check("word_valid_b", if_b.word_valid, m_valid);
      check("bit_count_a", count_a, 32'(m_bits.size()));
      check("bit_count_b", count_b, 32'(m_bits.size()));
      check("state_a", dbg_a, m_bits.size() == 15);
      if (m_valid) begin
        check("word_out_a", if_a.word_out, m_word_a);
        check("word_out_b", if_b.word_out, m_word_b);
      end
      if (!rst && if_a.word_valid && word_ready) begin
        if (exp_q.size() == 0) check("handoff_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("handoff_word", if_a.word_out, e);
        end
      end
    end
  end

  // driver: presents w[k] for k < n, waiting for acceptance of each bit
  task automatic send_bits(input logic [15:0] w, input int n, output int stalls);
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      bit took = 1'b0;
      bit_valid = 1'b1;
      bit_in = w[k];
      while (!took && guard < 64) begin
        @(negedge clk);
        took = if_a.bit_ready;
        @(posedge clk);
        #1;
        if (!took) begin
          stalls++;
          guard++;
        end
      end
      if (!took) begin
        check("send_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int s1, s2, c1, c2;
    rst = 1'b1; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_word_out", if_a.word_out, 16'h0000);
    check("rst_word_valid", if_a.word_valid, 0);
    check("rst_bit_count", count_a, 0);
    check("rst_bit_ready", if_a.bit_ready, 0);
    rst = 1'b0;
    word_ready = 1'b1;

    // T1: single word, one-cycle pulse
    send_bits(16'hA5C3, 16, s1);
    check("t1_word", if_a.word_out, 16'hA5C3);
    check("t1_valid", if_a.word_valid, 1);
    check("t1_count", count_a, 0);
    idle(1);
    check("t1_pulse_end", if_a.word_valid, 0);

    // T2: back-to-back words, no stall, 16 cycles apart
    send_bits(16'h1234, 16, s1);
    c1 = cyc;
    check("t2_word1", if_a.word_out, 16'h1234);
    send_bits(16'hFFFF, 16, s2);
    c2 = cyc;
    check("t2_word2", if_a.word_out, 16'hFFFF);
    check("t2_valid2", if_a.word_valid, 1);
    check("t2_stalls", s1 + s2, 0);
    check("t2_spacing", c2 - c1, 16);
    idle(2);

    // T3: backpressure stalls only the completing bit
    word_ready = 1'b0;
    send_bits(16'h00FF, 16, s1);
    check("t3_pending", if_a.word_valid, 1);
    send_bits(16'hF0F0, 15, s1);
    check("t3_no_stall15", s1, 0);
    check("t3_count15", count_a, 15);
    bit_valid = 1'b1;
    bit_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_stalled", if_a.bit_ready, 0);
      check("t3_hold", if_a.word_out, 16'h00FF);
      @(posedge clk);
      #1;
    end
    word_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ready", if_a.bit_ready, 1);
    @(posedge clk);
    #1;
    check("t3_word", if_a.word_out, 16'hF0F0);
    check("t3_valid", if_a.word_valid, 1);
    idle(2);

    // T4: clear drops partial word and rejects the bit offered alongside it
    send_bits(16'h001F, 5, s1);
    check("t4_count5", count_a, 5);
    clear = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(negedge clk);
    check("t4_clear_ready", if_a.bit_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bit_valid = 1'b0;
    check("t4_count0", count_a, 0);
    send_bits(16'h0000, 16, s1);
    check("t4_word", if_a.word_out, 16'h0000);
    check("t4_valid", if_a.word_valid, 1);
    idle(2);

    // T5: reset mid-word with a word pending
    word_ready = 1'b0;
    send_bits(16'h5A5A, 16, s1);
    send_bits(16'h01FF, 9, s1);
    check("t5_count9", count_a, 9);
    rst = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t5_valid", if_a.word_valid, 0);
    check("t5_word", if_a.word_out, 16'h0000);
    check("t5_count", count_a, 0);
    rst = 1'b0;
    word_ready = 1'b1;
    send_bits(16'hBEEF, 16, s1);
    check("t5_fresh", if_a.word_out, 16'hBEEF);
    idle(2);

    // T6: bit order, both instances
    send_bits(16'h0003, 16, s1);
    check("t6_lsb_first", if_a.word_out, 16'h0003);
    check("t6_msb_first", if_b.word_out, 16'hC000);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit_valid = ($urandom_range(0, 3) != 0);
      bit_in = 1'($urandom_range(0, 1));
      word_ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clear = 1'b0;
    word_ready = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
